// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cacheline memory arbiter: FSM states, grant owner, latched request record.
// Also provides the line-alignment helper used when a request is latched.
package rv32i_types;

    localparam int perf_counter_width = 32;
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    typedef enum logic [1:0] {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D, ARB_RECOVER} arbiter_state_t;
    typedef enum logic {ARB_GRANT_I, ARB_GRANT_D} arbiter_grant_t;

    typedef struct packed {
        logic         write;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } arb_req_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_sat_perf_counter.sv
// Saturating event counter: +1 per cycle with inc high, sticks at all-ones.
// Latency: count reflects inc one cycle later; no backpressure.
module sat_perf_counter
    import rv32i_types::*;
#(
    parameter int PERF_W = perf_counter_width
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    localparam logic [PERF_W-1:0] MAX_COUNT = {PERF_W{1'b1}};
    localparam logic [PERF_W-1:0] ONE       = {{(PERF_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != MAX_COUNT)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin share of the cacheline adaptor port between I-cache and D-cache, plus wait counters.
// Latency: grant one cycle after request in IDLE; resp is combinational from mem_resp; one RECOVER cycle.
module cache_mem_arbiter
    import rv32i_types::*;
#(
    parameter int PERF_W = perf_counter_width
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_pmem_read,
    input  logic [31:0]       icache_pmem_address,
    output logic [255:0]      icache_pmem_rdata,
    output logic              icache_pmem_resp,
    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [31:0]       dcache_pmem_address,
    input  logic [255:0]      dcache_pmem_wdata,
    output logic [255:0]      dcache_pmem_rdata,
    output logic              dcache_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [255:0]      mem_wdata,
    input  logic [255:0]      mem_rdata,
    input  logic              mem_resp,
    output logic [PERF_W-1:0] i_wait_count,
    output logic [PERF_W-1:0] d_wait_count
);

    arbiter_state_t state_q;
    arbiter_state_t state_d;
    arbiter_grant_t last_grant_q;
    arb_req_t       req_q;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;

    assign i_req = icache_pmem_read;
    assign d_req = dcache_pmem_read | dcache_pmem_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Contention in IDLE goes to whichever cache was not granted last.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (i_req && d_req) begin
                    state_d = (last_grant_q == ARB_GRANT_I) ? ARB_SERVE_D : ARB_SERVE_I;
                end else if (i_req) begin
                    state_d = ARB_SERVE_I;
                end else if (d_req) begin
                    state_d = ARB_SERVE_D;
                end
            end
            ARB_SERVE_I,
            ARB_SERVE_D: begin
                if (mem_resp) begin
                    state_d = ARB_RECOVER;
                end
            end
            ARB_RECOVER: state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    assign grant_i = (state_q == ARB_IDLE) && (state_d == ARB_SERVE_I);
    assign grant_d = (state_q == ARB_IDLE) && (state_d == ARB_SERVE_D);

    // The adaptor only ever sees these latched copies, so caches may change inputs mid-transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= ARB_GRANT_I;
            req_q        <= '0;
        end else if (grant_i) begin
            last_grant_q <= ARB_GRANT_I;
            req_q.write  <= 1'b0;
            req_q.addr   <= line_align(icache_pmem_address);
            req_q.wdata  <= '0;
        end else if (grant_d) begin
            last_grant_q <= ARB_GRANT_D;
            req_q.write  <= dcache_pmem_write;
            req_q.addr   <= line_align(dcache_pmem_address);
            req_q.wdata  <= dcache_pmem_wdata;
        end
    end

    always_comb begin
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        icache_pmem_resp = 1'b0;
        dcache_pmem_resp = 1'b0;
        case (state_q)
            ARB_SERVE_I: begin
                mem_read         = 1'b1;
                icache_pmem_resp = mem_resp;
            end
            ARB_SERVE_D: begin
                mem_read         = ~req_q.write;
                mem_write        = req_q.write;
                dcache_pmem_resp = mem_resp;
            end
            default: ;
        endcase
    end

    assign mem_address       = req_q.addr;
    assign mem_wdata         = req_q.wdata;
    assign icache_pmem_rdata = mem_rdata;
    assign dcache_pmem_rdata = mem_rdata;

    sat_perf_counter #(.PERF_W(PERF_W)) u_i_wait (
        .clk   (clk),
        .rst   (rst),
        .inc   (i_req && (state_q != ARB_SERVE_I)),
        .count (i_wait_count)
    );

    sat_perf_counter #(.PERF_W(PERF_W)) u_d_wait (
        .clk   (clk),
        .rst   (rst),
        .inc   (d_req && (state_q != ARB_SERVE_D)),
        .count (d_wait_count)
    );

endmodule
